sprite_layer: RTL and testbench

Positioned, scaled, animated sprite renderer for the VGA pixel path. It replaces the full-screen stretch sprite examples. It draws one SPR_W×SPR_H sprite at a per-frame position with an integer power-of-two scale, selects among FRAMES animation frames, and flags transparent pixels so a downstream compositor can layer it over background or other sprites. Sprite ROM and palette are external, so each character instantiates its own ROM and palette with this block.

---
 rtl/sprite_layer.sv | 179 +++++++++++++++++
 tb/tb_sprite_layer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - positioned, power-of-two scaled, animated sprite renderer (optional mirror: SPRITE_LAYER_FLIP_EN)
module sprite_layer #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int FRAMES     = 4,
    parameter int SCALE_SH   = 1,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8,
    parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H),
    parameter int FRM_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip,
    input  logic              anim_en,
    input  logic [FRM_W-1:0]  base_frame,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_r,
    input  logic [3:0]        pal_g,
    input  logic [3:0]        pal_b,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // On-screen footprint of the sprite, in 11 bits so sx + span never wraps.
    localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_SH);
    localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_SH);

    // Per-frame shadow copies of the placement inputs.
    logic [9:0]       sx;
    logic [9:0]       sy;
    logic             sflip;
    logic [FRM_W-1:0] cur_frame;
    logic [DIV_W-1:0] div_cnt;

    // Delayed qualifiers travelling alongside the pixel data.
    logic blank_d1;
    logic blank_d2;
    logic in_box_d1;
    logic in_box_d2;

    // Stage-1 combinational geometry.
    logic [10:0]       x11;
    logic [10:0]       y11;
    logic [10:0]       sx11;
    logic [10:0]       sy11;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              in_x;
    logic              in_y;
    logic              in_box;
    logic [COL_W-1:0]  col_raw;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_c;
    logic              opaque;

    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign sx11 = {1'b0, sx};
    assign sy11 = {1'b0, sy};
    assign dx   = x11 - sx11;
    assign dy   = y11 - sy11;

    assign in_x   = (x11 >= sx11) && (x11 < sx11 + SPAN_X);
    assign in_y   = (y11 >= sy11) && (y11 < sy11 + SPAN_Y);
    assign in_box = in_x && in_y;

    // Texel coordinates: screen offset divided by the scale factor.
    assign col_raw = COL_W'(dx >> SCALE_SH);
    assign row     = ROW_W'(dy >> SCALE_SH);

`ifdef SPRITE_LAYER_FLIP_EN
    assign col = sflip ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
`else
    logic unused_flip;
    assign unused_flip = flip ^ sflip;
    assign col = col_raw;
`endif

    // Frames, rows and columns are powers of two, so the linear address packs as fields.
    assign addr_c = in_box ? ((ADDR_W'(cur_frame) << (ROW_W + COL_W))
                             | (ADDR_W'(row) << COL_W)
                             | ADDR_W'(col))
                           : '0;

    assign pal_index = rom_q;
    assign opaque    = blank_d2 && in_box_d2 && (rom_q != IDX_W'(TRANSP_IDX));

    // Latch placement and advance animation only at frame_start to avoid tearing.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx        <= '0;
            sy        <= '0;
            sflip     <= 1'b0;
            cur_frame <= '0;
            div_cnt   <= '0;
        end else if (frame_start) begin
            sx <= pos_x;
            sy <= pos_y;
`ifdef SPRITE_LAYER_FLIP_EN
            sflip <= flip;
`else
            sflip <= 1'b0;
`endif
            if (anim_en) begin
                if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                    div_cnt   <= '0;
                    cur_frame <= (cur_frame == FRM_W'(FRAMES - 1)) ? '0 : cur_frame + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                cur_frame <= base_frame;
                div_cnt   <= '0;
            end
        end
    end

    // Stage 1: register the ROM address and the pixel qualifiers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            blank_d1  <= 1'b0;
            in_box_d1 <= 1'b0;
        end else begin
            rom_addr  <= addr_c;
            blank_d1  <= blank;
            in_box_d1 <= in_box;
        end
    end

    // Stage 2: qualifiers wait one cycle while the ROM registers rom_q.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_d2  <= 1'b0;
            in_box_d2 <= 1'b0;
        end else begin
            blank_d2  <= blank_d1;
            in_box_d2 <= in_box_d1;
        end
    end

    // Stage 3: register palette colour for opaque in-box active pixels, black otherwise.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            sprite_hit <= 1'b0;
        end else if (opaque) begin
            red        <= pal_r;
            green      <= pal_g;
            blue       <= pal_b;
            sprite_hit <= 1'b1;
        end else begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            sprite_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - self-checking bench for sprite_layer against a behavioural model
module tb_sprite_layer;

    localparam int SW = 64;
    localparam int SH = 64;
    localparam int FR = 4;
    localparam int SC = 1;
    localparam int AD = 8;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        flip = 1'b0;
    logic        anim_en = 1'b0;
    logic [1:0]  base_frame = '0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pal_index;
    logic [3:0]  pal_r, pal_g, pal_b;
    logic [3:0]  red, green, blue;
    logic        sprite_hit;

    logic [3:0]  rom_mem [16384];
    logic [11:0] pal_tab [16];

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int  m_sx, m_sy, m_frame, m_div;
    bit  m_flip;
    logic [12:0] oq[$];

    sprite_layer #(
        .SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .SCALE_SH(SC), .IDX_W(4),
        .TRANSP_IDX(0), .ANIM_DIV(AD)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .flip(flip), .anim_en(anim_en), .base_frame(base_frame),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

    assign {pal_r, pal_g, pal_b} = pal_tab[pal_index];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_sx = 0; m_sy = 0; m_frame = 0; m_div = 0; m_flip = 0;
        oq.delete();
        oq.push_back(13'h0);
        oq.push_back(13'h0);
    endfunction

    function automatic void model_frame();
        m_sx = int'(pos_x);
        m_sy = int'(pos_y);
`ifdef SPRITE_LAYER_FLIP_EN
        m_flip = flip;
`else
        m_flip = 0;
`endif
        if (anim_en) begin
            m_div = m_div + 1;
            if (m_div == AD) begin
                m_div = 0;
                m_frame = (m_frame + 1) % FR;
            end
        end else begin
            m_frame = int'(base_frame);
            m_div = 0;
        end
    endfunction

    function automatic void model_pix(input int x, input int y, input bit b,
                                      output int addr, output logic [12:0] o);
        int col, row, idx;
        bit inb;
        inb = (x >= m_sx) && (x < m_sx + SW * (1 << SC)) &&
              (y >= m_sy) && (y < m_sy + SH * (1 << SC));
        addr = 0;
        if (inb) begin
            col = (x - m_sx) / (1 << SC);
            row = (y - m_sy) / (1 << SC);
            if (m_flip) col = SW - 1 - col;
            addr = m_frame * SW * SH + row * SW + col;
        end
        idx = int'(rom_mem[addr]);
        o = (b && inb && idx != 0) ? {1'b1, pal_tab[idx]} : 13'h0;
    endfunction

    task automatic cyc(input int x, input int y, input bit b, input bit fs);
        int a;
        logic [12:0] o, eo;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        frame_start = fs;
        model_pix(x, y, b, a, o);
        oq.push_back(o);
        if (fs) model_frame();
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        chk("rom_addr", int'(rom_addr), a);
        eo = oq.pop_front();
        chk("pixel_out", int'({sprite_hit, red, green, blue}), int'(eo));
    endtask

    initial begin
        int x, y;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) pal_tab[i] = 12'($urandom);

        // Reset state.
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_state", int'({rom_addr, sprite_hit, red, green, blue}), 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();

        // Basic placement and scale.
        pos_x = 10'd100; pos_y = 10'd50; anim_en = 1'b0; base_frame = 2'd2; flip = 1'b0;
        rom_mem[8192] = 4'd0;
        rom_mem[8257] = 4'd5;
        pal_tab[5]    = 12'hF80;
        cyc(0, 0, 0, 1);
        cyc(100, 50, 1, 0);
        chk("tp_addr_100_50", int'(rom_addr), 8192);
        cyc(101, 51, 1, 0);
        chk("tp_addr_101_51", int'(rom_addr), 8192);
        cyc(102, 52, 1, 0);
        chk("tp_addr_102_52", int'(rom_addr), 8257);
        chk("transparent", int'({sprite_hit, red, green, blue}), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("opaque_lat3", int'({sprite_hit, red, green, blue}), 13'h1F80);

        // Horizontal containment edges.
        cyc(99, 60, 1, 0);
        chk("left_edge_addr", int'(rom_addr), 0);
        cyc(228, 60, 1, 0);
        chk("right_edge_addr", int'(rom_addr), 0);
        cyc(227, 60, 1, 0);
        chk("last_col_addr", int'(rom_addr), 8192 + 5 * 64 + 63);
        chk("left_edge_out", int'({sprite_hit, red, green, blue}), 0);
        cyc(0, 0, 0, 0);
        chk("right_edge_out", int'({sprite_hit, red, green, blue}), 0);
        cyc(0, 0, 0, 0);

        // Put an opaque pixel on the output, then reset asynchronously mid-line.
        rom_mem[8193] = 4'd5;
        cyc(102, 50, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pre_reset_hit", int'(sprite_hit), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", int'({rom_addr, sprite_hit, red, green, blue}), 0);
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();

        // Animation: 8 pulses advance one frame, 32 wrap back to frame 0.
        anim_en = 1'b1;
        for (int i = 0; i < 8; i++) cyc(100, 50, 1, 1);
        cyc(100, 50, 1, 0);
        chk("anim_frame1", int'(rom_addr), 4096);
        for (int i = 0; i < 24; i++) cyc(100, 50, 1, 1);
        cyc(100, 50, 1, 0);
        chk("anim_wrap0", int'(rom_addr), 0);

        // Position change between pulses has no effect.
        anim_en = 1'b0; base_frame = 2'd1; pos_x = 10'd200; pos_y = 10'd100;
        cyc(0, 0, 0, 1);
        pos_x = 10'd300;
        base_frame = 2'd3;
        cyc(200, 100, 1, 0);
        chk("shadow_hold", int'(rom_addr), 4096);

        // Mirror request.
        pos_x = 10'd200;
        flip = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(200, 100, 1, 0);
`ifdef SPRITE_LAYER_FLIP_EN
        chk("flip_col0", int'(rom_addr), 3 * 4096 + 63);
`else
        chk("flip_col0", int'(rom_addr), 3 * 4096);
`endif
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Randomized frames around random placements, including screen-edge clipping.
        for (int f = 0; f < 8; f++) begin
            int px, py;
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 1023);
            pos_x = 10'(px); pos_y = 10'(py);
            flip = 1'($urandom);
            anim_en = 1'($urandom);
            base_frame = 2'($urandom);
            cyc($urandom_range(0, 1023), $urandom_range(0, 1023), 1, 1);
            for (int p = 0; p < 150; p++) begin
                x = px + $urandom_range(0, 135) - 4;
                y = py + $urandom_range(0, 135) - 4;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                if ($urandom_range(0, 19) == 0) pos_x = 10'($urandom);
                if ($urandom_range(0, 19) == 0) base_frame = 2'($urandom);
                cyc(x, y, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
                px = m_sx;
                py = m_sy;
            end
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
